// File: rtl/multi_phase_traffic_ctrl.sv
// N-phase round-robin traffic-light controller: tick prescaler, latched demand, minimum green, rest-on-green.
// Define TLC_ALL_RED_EN to insert an all-red clearance interval between YELLOW and the next GREEN.
module multi_phase_traffic_ctrl #(
  parameter int N_PHASES    = 2,
  parameter int CNT_W       = 6,
  parameter int TICK_DIV    = 5,
  parameter int T_GREEN_MIN = 5,
  parameter int T_YELLOW    = 2,
  parameter int T_ALLRED    = 1,
  parameter int HOME_PHASE  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PHASES-1:0]         req,
  output logic [N_PHASES-1:0]         lamp_g,
  output logic [N_PHASES-1:0]         lamp_y,
  output logic [N_PHASES-1:0]         lamp_r,
  output logic [$clog2(N_PHASES)-1:0] active_phase,
  output logic [CNT_W-1:0]            sec_count,
  output logic                        tick,
  output logic                        phase_done
);

  localparam int PH_W = $clog2(N_PHASES);
  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] T_GRN   = CNT_W'(T_GREEN_MIN);
  localparam logic [CNT_W-1:0] T_YEL   = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [PH_W-1:0]  HOME    = PH_W'(HOME_PHASE);
`ifdef TLC_ALL_RED_EN
  localparam logic [CNT_W-1:0] T_AR    = CNT_W'(T_ALLRED);
`endif

  if (N_PHASES < 2 || N_PHASES > 8) begin : g_bad_n
    $error("multi_phase_traffic_ctrl: N_PHASES must be 2..8");
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $error("multi_phase_traffic_ctrl: TICK_DIV must be >= 1");
  end
  if (HOME_PHASE < 0 || HOME_PHASE >= N_PHASES) begin : g_bad_home
    $error("multi_phase_traffic_ctrl: HOME_PHASE out of range");
  end
  if (T_GREEN_MIN < 1 || T_GREEN_MIN >= (1 << CNT_W) ||
      T_YELLOW    < 1 || T_YELLOW    >= (1 << CNT_W) ||
      T_ALLRED    < 1 || T_ALLRED    >= (1 << CNT_W)) begin : g_bad_t
    $error("multi_phase_traffic_ctrl: T_* parameters must be 1..2^CNT_W-1");
  end

`ifdef TLC_ALL_RED_EN
  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED} state_t;
`else
  typedef enum logic {S_GREEN, S_YELLOW} state_t;
`endif

  state_t               state;
  logic [PH_W-1:0]      next_phase;
  logic [PS_W-1:0]      presc;
  logic [PS_W-1:0]      presc_nxt;
  logic [N_PHASES-1:0]  pending;
  logic [N_PHASES-1:0]  pending_nxt;
  logic [N_PHASES-1:0]  block;
  logic [N_PHASES-1:0]  grant;
  logic [PH_W-1:0]      rr_phase;
  logic [PH_W-1:0]      rr_idx;
  logic                 tick_evt;
  logic                 leave;
  logic                 green_entry;

  function automatic logic [N_PHASES-1:0] onehot(input logic [PH_W-1:0] p);
    return N_PHASES'(1) << p;
  endfunction

  always_comb begin
    tick_evt = (presc == PS_LAST);
    case (state)
      S_GREEN: leave = (sec_count == '0) && (|pending);
      default: leave = tick_evt && (sec_count == ONE);
    endcase
`ifdef TLC_ALL_RED_EN
    green_entry = leave && (state == S_ALLRED);
`else
    green_entry = leave && (state == S_YELLOW);
`endif
    // Every state entry restarts the prescaler so intervals are exact multiples of TICK_DIV.
    presc_nxt   = (leave || tick_evt) ? '0 : presc + 1'b1;
    block       = (state == S_GREEN) ? onehot(active_phase) : '0;
    grant       = green_entry ? onehot(next_phase) : '0;
    pending_nxt = (pending | (req & ~block)) & ~grant;

    // Descending scan: the smallest offset from active_phase is assigned last and wins.
    rr_phase = active_phase;
    rr_idx   = '0;
    for (int off = N_PHASES; off >= 1; off--) begin
      rr_idx = PH_W'((int'(active_phase) + off) % N_PHASES);
      if (pending[rr_idx]) rr_phase = rr_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_GREEN;
      active_phase <= HOME;
      next_phase   <= HOME;
      sec_count    <= T_GRN;
      presc        <= '0;
      pending      <= '0;
      tick         <= 1'b0;
      phase_done   <= 1'b0;
      lamp_g       <= onehot(HOME);
      lamp_y       <= '0;
      lamp_r       <= ~onehot(HOME);
    end else begin
      presc      <= presc_nxt;
      tick       <= (presc_nxt == PS_LAST);
      pending    <= pending_nxt;
      phase_done <= green_entry;
      if (leave) begin
        case (state)
          S_GREEN: begin
            state      <= S_YELLOW;
            next_phase <= rr_phase;
            sec_count  <= T_YEL;
            lamp_g     <= '0;
            lamp_y     <= onehot(active_phase);
            lamp_r     <= ~onehot(active_phase);
          end
`ifdef TLC_ALL_RED_EN
          S_YELLOW: begin
            state     <= S_ALLRED;
            sec_count <= T_AR;
            lamp_y    <= '0;
            lamp_r    <= '1;
          end
`endif
          default: begin
            state        <= S_GREEN;
            active_phase <= next_phase;
            sec_count    <= T_GRN;
            lamp_g       <= onehot(next_phase);
            lamp_y       <= '0;
            lamp_r       <= ~onehot(next_phase);
          end
        endcase
      end else if (tick_evt && sec_count != '0) begin
        sec_count <= sec_count - ONE;
      end
    end
  end

endmodule

// File: tb/tb_multi_phase_traffic_ctrl.sv
// Directed bench for multi_phase_traffic_ctrl: a 2-phase instance and a 4-phase instance sharing clock and reset.
module tb_multi_phase_traffic_ctrl;

`ifdef TLC_ALL_RED_EN
  localparam int AR_CYC = 5;
`else
  localparam int AR_CYC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req2 = '0;
  logic [1:0] g2, y2, r2;
  logic [0:0] act2;
  logic [5:0] sec2;
  logic       tick2, done2;
  logic [3:0] req4 = '0;
  logic [3:0] g4, y4, r4;
  logic [1:0] act4;
  logic [5:0] sec4;
  logic       tick4, done4;

  int tests = 0;
  int fails = 0;
  int bad_lamp = 0;
  int bad_gap = 0;

  always #5 clk = ~clk;

  multi_phase_traffic_ctrl u_dut (
    .clk(clk), .rst(rst), .req(req2),
    .lamp_g(g2), .lamp_y(y2), .lamp_r(r2),
    .active_phase(act2), .sec_count(sec2), .tick(tick2), .phase_done(done2)
  );

  multi_phase_traffic_ctrl #(.N_PHASES(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req4),
    .lamp_g(g4), .lamp_y(y4), .lamp_r(r4),
    .active_phase(act4), .sec_count(sec4), .tick(tick4), .phase_done(done4)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (((g2 ^ y2 ^ r2) != 2'b11) || ((g2 & y2) | (g2 & r2) | (y2 & r2)) != 2'b00) bad_lamp++;
      if (((g4 ^ y4 ^ r4) != 4'hF) || ((g4 & y4) | (g4 & r4) | (y4 & r4)) != 4'h0) bad_lamp++;
      if (g2 == 2'b00 && r2[act2] == 1'b1) bad_gap++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_act4_leave(input logic [1:0] from, input int budget);
    for (int i = 0; i < budget && act4 == from; i++) @(negedge clk);
  endtask

  initial begin
    // Reset state and resting on the home phase
    step(2);
    check("rst_g", 32'(g2), 32'h1);
    check("rst_y", 32'(y2), 32'h0);
    check("rst_r", 32'(r2), 32'h2);
    check("rst_sec", 32'(sec2), 32'd5);
    rst = 1'b0;
    check("rel_act", 32'(act2), 32'd0);
    check("rel_tick", 32'(tick2), 32'd0);
    check("rel_done", 32'(done2), 32'd0);
    step(4);
    check("tick_e4", 32'(tick2), 32'd1);
    check("sec_e4", 32'(sec2), 32'd5);
    step(1);
    check("tick_e5", 32'(tick2), 32'd0);
    check("sec_e5", 32'(sec2), 32'd4);
    step(20);
    check("sec_e25", 32'(sec2), 32'd0);
    step(50);
    check("rest_sec", 32'(sec2), 32'd0);
    check("rest_g", 32'(g2), 32'h1);

    // One-cycle demand on phase 1 while resting
    req2 = 2'b10;
    step(1);
    req2 = 2'b00;
    check("k_green", 32'(g2), 32'h1);
    step(1);
    check("k1_y", 32'(y2), 32'h1);
    check("k1_g", 32'(g2), 32'h0);
    check("k1_r", 32'(r2), 32'h2);
    check("k1_sec", 32'(sec2), 32'd2);
    step(9);
    check("k10_y", 32'(y2), 32'h1);
    check("k10_sec", 32'(sec2), 32'd1);
    step(1);
`ifdef TLC_ALL_RED_EN
    check("k11_allred_r", 32'(r2), 32'h3);
    check("k11_allred_y", 32'(y2), 32'h0);
    step(4);
    check("k15_allred_r", 32'(r2), 32'h3);
    step(1);
`endif
    check("g_g", 32'(g2), 32'h2);
    check("g_r", 32'(r2), 32'h1);
    check("g_act", 32'(act2), 32'd1);
    check("g_done", 32'(done2), 32'd1);
    check("g_sec", 32'(sec2), 32'd5);
    check("g_pend", 32'(u_dut.pending), 32'h0);
    step(1);
    check("g1_done", 32'(done2), 32'd0);

    // Demand during minimum green is held until sec_count reaches 0
    req2 = 2'b01;
    step(1);
    req2 = 2'b00;
    step(22);
    check("g24_sec", 32'(sec2), 32'd1);
    check("g24_g", 32'(g2), 32'h2);
    step(1);
    check("g25_sec", 32'(sec2), 32'd0);
    check("g25_g", 32'(g2), 32'h2);
    step(1);
    check("g26_y", 32'(y2), 32'h2);
    check("g26_r", 32'(r2), 32'h1);
    check("g26_act", 32'(act2), 32'd1);

    // Asynchronous reset in the middle of YELLOW
    step(3);
    #2 rst = 1'b1;
    #1;
    check("arst_g", 32'(g2), 32'h1);
    check("arst_y", 32'(y2), 32'h0);
    check("arst_r", 32'(r2), 32'h2);
    check("arst_sec", 32'(sec2), 32'd5);
    check("arst_act", 32'(act2), 32'd0);
    check("arst_pend", 32'(u_dut.pending), 32'h0);
    step(1);
    rst = 1'b0;

    // Demand two cycles after reset waits out the minimum green
    step(1);
    req2 = 2'b10;
    step(1);
    req2 = 2'b00;
    step(22);
    check("r24_sec", 32'(sec2), 32'd1);
    check("r24_g", 32'(g2), 32'h1);
    step(1);
    check("r25_sec", 32'(sec2), 32'd0);
    check("r25_g", 32'(g2), 32'h1);
    step(1);
    check("r26_y", 32'(y2), 32'h1);
    check("r26_r", 32'(r2), 32'h2);
    step(10 + AR_CYC);
    check("r_next_g", 32'(g2), 32'h2);

    // Four-phase round robin: from phase 1, phases 3 and 0 pending -> 3 then 0
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("p4_rst_g", 32'(g4), 32'h1);
    req4 = 4'b0010;
    step(1);
    req4 = 4'b0000;
    wait_act4_leave(2'd0, 100);
    check("p4_act1", 32'(act4), 32'd1);
    check("p4_g1", 32'(g4), 32'h2);
    req4 = 4'b1001;
    step(1);
    req4 = 4'b0000;
    wait_act4_leave(2'd1, 100);
    check("p4_act3", 32'(act4), 32'd3);
    check("p4_g3", 32'(g4), 32'h8);
    wait_act4_leave(2'd3, 100);
    check("p4_act0", 32'(act4), 32'd0);
    check("p4_g0", 32'(g4), 32'h1);
    check("p4_pend", 32'(u_dut4.pending), 32'h0);

    check("lamp_onehot", 32'(bad_lamp), 32'd0);
`ifndef TLC_ALL_RED_EN
    check("no_dark_gap", 32'(bad_gap), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
